wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback result and results returned by long-latency units (multiplier/divider). Pipeline writes always win; long-latency results are queued in a small pending buffer and drained on idle port cycles. A busy-register scoreboard reports RAW/WAW hazards against outstanding long-latency destinations. Sits between the writeback stage and the register file.

---
 rtl/definitions_pkg.sv | 15 +
 rtl/wb_pend_fifo.sv | 56 +++++
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the writeback-port arbiter: register addresses, data words and
// the pending-result entry carried through the long-latency buffer.
package definitions_pkg;

    localparam int unsigned NumRegs = 32;

    typedef logic [31:0] word_st;
    typedef logic [4:0]  reg_addr_t;

    typedef struct packed {
        reg_addr_t rd;
        word_st    data;
    } wbq_entry_st;

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular FIFO holding long-latency results until the register-file port is free.
// Callers never push when full or pop when empty.
module wb_pend_fifo
    import definitions_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  wbq_entry_st              push_entry_i,
    input  logic                     pop_i,
    output wbq_entry_st              head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);

    wbq_entry_st     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered
// long-latency results, and tracks busy destinations of outstanding long-latency ops.
module wb_port_arbiter
    import definitions_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_we_i,
    input  reg_addr_t               wb_rd_i,
    input  word_st                  wb_data_i,
    input  logic                    lu_valid_i,
    output logic                    lu_ready_o,
    input  reg_addr_t               lu_rd_i,
    input  word_st                  lu_data_i,
    input  logic                    issue_i,
    input  reg_addr_t               issue_rd_i,
    input  reg_addr_t               rs1_i,
    input  reg_addr_t               rs2_i,
    output logic                    rs_busy_o,
    output logic                    wb_stall_o,
    output logic                    rf_we_o,
    output reg_addr_t               rf_rd_o,
    output word_st                  rf_data_o,
    output logic [$clog2(DEPTH):0]  pending_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
    localparam logic [StW-1:0]  StarveTop = StW'(STARVE_MAX - 1);
    localparam logic [StW-1:0]  StOne     = StW'(1);

    logic            pw;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CntW-1:0] count;
    wbq_entry_st     head;
    wbq_entry_st     push_entry;

    logic [NumRegs-1:1] busy_q;
    logic [NumRegs-1:1] busy_d;
    logic [NumRegs-1:0] busy_all;
    logic [NumRegs-1:0] busy_next_all;

    logic [StW-1:0] starve_q;
    logic           stall_q;

    assign pw    = wb_we_i && (wb_rd_i != '0);
    assign full  = (count == DepthCnt);
    assign empty = (count == '0);
    assign pop   = !pw && !empty;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign lu_ready_o = (count < DepthCnt);
    assign push       = lu_valid_i && lu_ready_o && (lu_rd_i != '0);
    assign push_entry = '{rd: lu_rd_i, data: lu_data_i};

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    always_comb begin
        rf_we_o   = 1'b0;
        rf_rd_o   = '0;
        rf_data_o = '0;
        if (pw) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = wb_rd_i;
            rf_data_o = wb_data_i;
        end else if (pop) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = head.rd;
            rf_data_o = head.data;
        end
    end

    assign busy_all = {busy_q, 1'b0};

    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_next_all = busy_all;
        if (pop) begin
            busy_next_all[head.rd] = 1'b0;
        end
        if (issue_i && (issue_rd_i != '0)) begin
            busy_next_all[issue_rd_i] = 1'b1;
        end
        busy_d = busy_next_all[NumRegs-1:1];
    end

    assign rs_busy_o = busy_all[rs1_i] | busy_all[rs2_i] | (issue_i & busy_all[issue_rd_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (pw && full) begin
                if (starve_q == StarveTop) begin
                    starve_q <= '0;
                    stall_q  <= 1'b1;
                end else begin
                    starve_q <= starve_q + StOne;
                    stall_q  <= 1'b0;
                end
            end else begin
                starve_q <= '0;
                stall_q  <= 1'b0;
            end
        end
    end

    assign wb_stall_o = stall_q;
    assign pending_o  = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed cycle table, mid-cycle reset sequence and a
// randomised phase checked against a scoreboard of accepted long-latency results.
module tb_wb_port_arbiter;
    import definitions_pkg::*;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    reg_addr_t   wb_rd;
    word_st      wb_data;
    logic        lu_valid;
    logic        lu_ready;
    reg_addr_t   lu_rd;
    word_st      lu_data;
    logic        issue;
    reg_addr_t   issue_rd;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic        rs_busy;
    logic        wb_stall;
    logic        rf_we;
    reg_addr_t   rf_rd;
    word_st      rf_data;
    logic [1:0]  pending;

    wb_port_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .lu_valid_i (lu_valid),
        .lu_ready_o (lu_ready),
        .lu_rd_i    (lu_rd),
        .lu_data_i  (lu_data),
        .issue_i    (issue),
        .issue_rd_i (issue_rd),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rs_busy_o  (rs_busy),
        .wb_stall_o (wb_stall),
        .rf_we_o    (rf_we),
        .rf_rd_o    (rf_rd),
        .rf_data_o  (rf_data),
        .pending_o  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
        logic        e_rdy;
        logic        e_busy;
        logic        e_stall;
        logic [1:0]  e_pend;
    } vec_t;

    vec_t        tbl[$];
    wbq_entry_st exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic vec_t row(
        input logic we, input logic [4:0] rd, input logic [31:0] wd,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic iss, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_d,
        input logic e_rdy, input logic e_busy, input logic e_stall, input logic [1:0] e_pend);
        vec_t v;
        v = '{we: we, rd: rd, wd: wd, lv: lv, lrd: lrd, ld: ld, iss: iss, ird: ird,
              rs1: r1, rs2: r2, e_we: e_we, e_rd: e_rd, e_d: e_d, e_rdy: e_rdy,
              e_busy: e_busy, e_stall: e_stall, e_pend: e_pend};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb_we    = v.we;
        wb_rd    = v.rd;
        wb_data  = v.wd;
        lu_valid = v.lv;
        lu_rd    = v.lrd;
        lu_data  = v.ld;
        issue    = v.iss;
        issue_rd = v.ird;
        rs1      = v.rs1;
        rs2      = v.rs2;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, "_rf_we"},    32'(rf_we),    32'(v.e_we));
        check({tag, "_rf_rd"},    32'(rf_rd),    32'(v.e_rd));
        check({tag, "_rf_data"},  rf_data,       v.e_d);
        check({tag, "_lu_ready"}, 32'(lu_ready), 32'(v.e_rdy));
        check({tag, "_rs_busy"},  32'(rs_busy),  32'(v.e_busy));
        check({tag, "_wb_stall"}, 32'(wb_stall), 32'(v.e_stall));
        check({tag, "_pending"},  32'(pending),  32'(v.e_pend));
    endtask

    // One cycle: drive after the edge, check at negedge, scoreboard drained results.
    task automatic apply_row(input string tag, input vec_t v);
        wbq_entry_st e;
        drive(v);
        @(negedge clk);
        check_outs(tag, v);
        if (rf_we && !(v.we && v.rd != 5'd0)) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_unexpected_write"}, 32'(rf_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_sb_rd"},   32'(rf_rd), 32'(e.rd));
                check({tag, "_sb_data"}, rf_data,    e.data);
            end
        end
        if (v.lv && v.e_rdy && v.lrd != 5'd0) begin
            exp_q.push_back('{rd: v.lrd, data: v.ld});
        end
        @(posedge clk);
        #1;
    endtask

    vec_t idle_v;
    int   mcount;
    int   mstarve;
    logic mstall;

    initial begin
        idle_v = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst_n  = 1'b0;
        drive(idle_v);
        #1;
        check_outs("reset", idle_v);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle port: result buffered one cycle, busy clears the cycle after the pop.
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0));
        // Pipeline priority over a buffered entry.
        tbl.push_back(row(0, 0, 0, 1, 9, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(1, 3, 32'hA5A50003, 0, 0, 0, 0, 0, 0, 0,
                              1, 3, 32'hA5A50003, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h11111111, 1, 0, 0, 1));
        tbl.push_back(idle_v);
        // Full buffer under continuous pipeline writes, starvation bubble.
        tbl.push_back(row(1, 4, 4, 1, 10, 32'hAAAA000A, 0, 0, 0, 0, 1, 4, 4, 1, 0, 0, 0));
        tbl.push_back(row(1, 4, 4, 1, 11, 32'hBBBB000B, 0, 0, 0, 0, 1, 4, 4, 1, 0, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(1, 4, 4, 1, 12, 32'hCCCC000C, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, 1, 12, 32'hCCCC000C, 0, 0, 0, 0,
                          1, 10, 32'hAAAA000A, 0, 0, 1, 2));
        tbl.push_back(row(1, 4, 4, 1, 12, 32'hCCCC000C, 0, 0, 0, 0, 1, 4, 4, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 32'hBBBB000B, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 32'hCCCC000C, 1, 0, 0, 1));
        tbl.push_back(idle_v);
        // x0 handling on both sources.
        tbl.push_back(row(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 13, 32'h00000D13, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'h00000D13, 1, 0, 0, 1));
        tbl.push_back(idle_v);
        // Scoreboard race: re-issue of rd=7 in the cycle its older result pops.
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 7, 32'h77, 1, 1, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row($sformatf("r%0d", i), tbl[i]);
        end

        // Mid-cycle asynchronous reset with two entries pending and busy bits set.
        apply_row("h0", row(0, 0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        apply_row("h1", row(1, 1, 1, 1, 20, 32'h20, 1, 21, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        apply_row("h2", row(1, 2, 2, 1, 21, 32'h21, 0, 0, 0, 0, 1, 2, 2, 1, 0, 0, 1));
        drive(row(0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 1, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", row(0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 1, 0, 0, 0));
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_row("post_rst", row(0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 1, 0, 0, 0));

        // Randomised traffic against an occupancy/starvation model and the scoreboard.
        mcount  = 0;
        mstarve = 0;
        mstall  = 1'b0;
        for (int c = 0; c < 300 + 12; c++) begin
            logic        rwe;
            logic [4:0]  rrd;
            logic [31:0] rwd;
            logic        rlv;
            logic [4:0]  rlrd;
            logic        mpw;
            logic        mpush;
            logic        mpop;
            wbq_entry_st e;
            bit          drain;
            drain = (c >= 300);
            if (drain && mcount == 0 && !mstall) break;
            rwe  = !mstall && !drain && ($urandom_range(0, 3) != 0);
            rrd  = 5'($urandom_range(0, 15));
            rwd  = $urandom;
            rlv  = !drain && ($urandom_range(0, 1) != 0);
            rlrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
            wb_we    = rwe;
            wb_rd    = rrd;
            wb_data  = rwd;
            lu_valid = rlv;
            lu_rd    = rlrd;
            lu_data  = $urandom;
            issue    = 1'b0;
            issue_rd = '0;
            rs1      = '0;
            rs2      = '0;
            @(negedge clk);
            mpw = rwe && (rrd != 5'd0);
            check("rnd_lu_ready", 32'(lu_ready), 32'(mcount < DEPTH));
            check("rnd_pending",  32'(pending),  32'(mcount));
            check("rnd_wb_stall", 32'(wb_stall), 32'(mstall));
            if (mpw) begin
                check("rnd_pw_we",   32'(rf_we), 32'd1);
                check("rnd_pw_rd",   32'(rf_rd), 32'(rrd));
                check("rnd_pw_data", rf_data,    rwd);
            end else if (mcount > 0) begin
                e = exp_q.pop_front();
                check("rnd_sb_we",   32'(rf_we), 32'd1);
                check("rnd_sb_rd",   32'(rf_rd), 32'(e.rd));
                check("rnd_sb_data", rf_data,    e.data);
            end else begin
                check("rnd_idle_we", 32'(rf_we), 32'd0);
            end
            mpop  = !mpw && (mcount > 0);
            mpush = rlv && (mcount < DEPTH) && (rlrd != 5'd0);
            if (mpush) exp_q.push_back('{rd: rlrd, data: lu_data});
            if (mpw && mcount == DEPTH) begin
                if (mstarve == STARVE_MAX - 1) begin
                    mstarve = 0;
                    mstall  = 1'b1;
                end else begin
                    mstarve++;
                    mstall = 1'b0;
                end
            end else begin
                mstarve = 0;
                mstall  = 1'b0;
            end
            mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(pending), 32'd0);
        check("drain_sb_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
